bit_stream_decoder: RTL

Receive-side packet parser for the USB path; inverse of the transmit bit stream encoder. Consumes the de-NRZI'd, unstuffed serial bit stream (one qualified bit per cycle), hunts SYNC, decodes and checks the PID, and extracts token fields (addr/endp) or an 8-byte data payload. It checks CRC5/CRC16 and reports a one-cycle packet-done strobe with status flags at EOP. It sits between the rx unstuffer and the protocol FSM.

---
 rtl/bit_stream_decoder_if.sv | 33 +++
 rtl/bit_stream_decoder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/bit_stream_decoder_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | bit_stream_decoder_if
// | Serial bit input side and decoded packet result side of the rx parser.
// | Rev 1.0
// +-----------------------------------------------------------------------------
interface bit_stream_decoder_if;
  logic        bit_in;
  logic        bit_valid;
  logic        eop;
  logic        pkt_done;
  logic        pkt_ok;
  logic        err_pid;
  logic        err_crc;
  logic        err_len;
  logic [3:0]  pid_out;
  logic [6:0]  addr_out;
  logic [3:0]  endp_out;
  logic [63:0] data_out;

  modport master (
    output bit_in, bit_valid, eop,
    input  pkt_done, pkt_ok, err_pid, err_crc, err_len,
    input  pid_out, addr_out, endp_out, data_out
  );

  modport slave (
    input  bit_in, bit_valid, eop,
    output pkt_done, pkt_ok, err_pid, err_crc, err_len,
    output pid_out, addr_out, endp_out, data_out
  );
endinterface
`default_nettype wire

// File: rtl/bit_stream_decoder.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | bit_stream_decoder
// | USB rx packet parser: SYNC hunt, PID check, token/data field extraction,
// | CRC5/CRC16 residual check when BSD_CRC_CHECK_EN is defined.
// | Rev 1.0
// +-----------------------------------------------------------------------------
module bit_stream_decoder (
  input wire                  clk,
  input wire                  rst,
  bit_stream_decoder_if.slave bus
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PID   = 3'd1;
  localparam logic [2:0] S_TOKEN = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;

  logic [2:0]  state_q, state_d, adv_state;
  logic [6:0]  win_q, win_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [7:0]  pid_q, pid_d;
  logic [63:0] sr_q, sr_d;
  logic        pid_bad_q, pid_bad_d, len_over_q, len_over_d;
  logic        done_q, done_d, ok_q, ok_d;
  logic        err_pid_q, err_pid_d, err_crc_q, err_crc_d, err_len_q, err_len_d;
  logic [3:0]  pid_out_q, pid_out_d, endp_q, endp_d;
  logic [6:0]  addr_q, addr_d;
  logic [63:0] data_q, data_d;

  logic [7:0]  pid_byte;
  logic        pid_good, sync_hit, end_pkt, tok_crc_bad, dat_crc_bad;
  logic [6:0]  cnt_sat, pay_len;

  assign pid_byte = {bus.bit_in, pid_q[7:1]};
  assign pid_good = (pid_byte[7:4] == ~pid_byte[3:0]) && (pid_byte[1:0] != 2'b00);
  // Seven stored bits plus the current one; cnt_q guarantees they are fresh.
  assign sync_hit = (cnt_q >= 7'd7) && ({bus.bit_in, win_q} == 8'h80);
  assign end_pkt  = bus.eop && (state_q != S_IDLE);
  assign cnt_sat  = (cnt_q == 7'd127) ? cnt_q : cnt_q + 7'd1;
  assign pay_len  = (state_q == S_TOKEN) ? 7'd11 : 7'd64;

`ifdef BSD_CRC_CHECK_EN
  logic [4:0]  crc5_q, crc5_d;
  logic [15:0] crc16_q, crc16_d;

  always_comb begin
    crc5_d  = crc5_q;
    crc16_d = crc16_q;
    if (bus.bit_valid) begin
      if (state_q == S_PID && cnt_q == 7'd7) begin
        crc5_d  = 5'h1F;
        crc16_d = 16'hFFFF;
      end else if (state_q == S_TOKEN && cnt_q < 7'd16) begin
        crc5_d = {crc5_q[3:0], 1'b0} ^ ({5{bus.bit_in ^ crc5_q[4]}} & 5'h05);
      end else if (state_q == S_DATA && cnt_q < 7'd80) begin
        crc16_d = {crc16_q[14:0], 1'b0} ^ ({16{bus.bit_in ^ crc16_q[15]}} & 16'h8005);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      crc5_q  <= '0;
      crc16_q <= '0;
    end else begin
      crc5_q  <= crc5_d;
      crc16_q <= crc16_d;
    end
  end

  assign tok_crc_bad = (crc5_d != 5'b01100);
  assign dat_crc_bad = (crc16_d != 16'h800D);
`else
  assign tok_crc_bad = 1'b0;
  assign dat_crc_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      win_q      <= '0;
      cnt_q      <= '0;
      pid_q      <= '0;
      sr_q       <= '0;
      pid_bad_q  <= 1'b0;
      len_over_q <= 1'b0;
      done_q     <= 1'b0;
      ok_q       <= 1'b0;
      err_pid_q  <= 1'b0;
      err_crc_q  <= 1'b0;
      err_len_q  <= 1'b0;
      pid_out_q  <= '0;
      addr_q     <= '0;
      endp_q     <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      cnt_q      <= cnt_d;
      pid_q      <= pid_d;
      sr_q       <= sr_d;
      pid_bad_q  <= pid_bad_d;
      len_over_q <= len_over_d;
      done_q     <= done_d;
      ok_q       <= ok_d;
      err_pid_q  <= err_pid_d;
      err_crc_q  <= err_crc_d;
      err_len_q  <= err_len_d;
      pid_out_q  <= pid_out_d;
      addr_q     <= addr_d;
      endp_q     <= endp_d;
      data_q     <= data_d;
    end
  end

  // adv_state is where the current bit takes us; eop is judged against it.
  always_comb begin
    adv_state = state_q;
    if (bus.bit_valid) begin
      case (state_q)
        S_IDLE: if (sync_hit) adv_state = S_PID;
        S_PID: begin
          if (cnt_q == 7'd7) begin
            if (!pid_good)                  adv_state = S_WAIT;
            else if (pid_byte[1:0] == 2'b01) adv_state = S_TOKEN;
            else if (pid_byte[1:0] == 2'b11) adv_state = S_DATA;
            else                             adv_state = S_WAIT;
          end
        end
        default: adv_state = state_q;
      endcase
    end
    state_d = end_pkt ? S_IDLE : adv_state;
  end

  always_comb begin
    win_d      = win_q;
    cnt_d      = cnt_q;
    pid_d      = pid_q;
    sr_d       = sr_q;
    pid_bad_d  = pid_bad_q;
    len_over_d = len_over_q;
    done_d     = 1'b0;
    ok_d       = 1'b0;
    err_pid_d  = 1'b0;
    err_crc_d  = 1'b0;
    err_len_d  = 1'b0;
    pid_out_d  = pid_out_q;
    addr_d     = addr_q;
    endp_d     = endp_q;
    data_d     = data_q;

    if (bus.bit_valid) begin
      case (state_q)
        S_IDLE: begin
          win_d = {bus.bit_in, win_q[6:1]};
          cnt_d = cnt_sat;
          if (sync_hit) begin
            win_d = '0;
            cnt_d = '0;
          end
        end
        S_PID: begin
          pid_d = pid_byte;
          cnt_d = cnt_sat;
          if (cnt_q == 7'd7) begin
            cnt_d     = '0;
            pid_bad_d = !pid_good;
          end
        end
        S_TOKEN, S_DATA: begin
          cnt_d = cnt_sat;
          // Field bits enter at the top so the k-th bit settles in bit k.
          if (cnt_q < pay_len) sr_d = {bus.bit_in, sr_q[63:1]};
        end
        S_WAIT: if (!pid_bad_q) len_over_d = 1'b1;
        default: ;
      endcase
    end

    if (end_pkt) begin
      done_d = 1'b1;
      case (adv_state)
        S_PID: err_len_d = 1'b1;
        S_TOKEN: begin
          err_len_d = (cnt_d != 7'd16);
          err_crc_d = (cnt_d == 7'd16) && tok_crc_bad;
          pid_out_d = pid_d[3:0];
          addr_d    = sr_d[59:53];
          endp_d    = sr_d[63:60];
        end
        S_DATA: begin
          err_len_d = (cnt_d != 7'd80);
          err_crc_d = (cnt_d == 7'd80) && dat_crc_bad;
          pid_out_d = pid_d[3:0];
          data_d    = sr_d;
        end
        S_WAIT: begin
          err_pid_d = pid_bad_d;
          err_len_d = len_over_d;
          pid_out_d = pid_d[3:0];
        end
        default: ;
      endcase
      ok_d       = !(err_pid_d || err_crc_d || err_len_d);
      win_d      = '0;
      cnt_d      = '0;
      pid_bad_d  = 1'b0;
      len_over_d = 1'b0;
    end
  end

  assign bus.pkt_done = done_q;
  assign bus.pkt_ok   = ok_q;
  assign bus.err_pid  = err_pid_q;
  assign bus.err_crc  = err_crc_q;
  assign bus.err_len  = err_len_q;
  assign bus.pid_out  = pid_out_q;
  assign bus.addr_out = addr_q;
  assign bus.endp_out = endp_q;
  assign bus.data_out = data_q;
endmodule
`default_nettype wire
